// File: rtl/alt_vipitc131_common_mode_select_pkg.sv
// Shared definitions for the clocked-video-output mode selector: FSM state
// encoding, the "no mode" constant and the index+1 priority encode function.
package alt_vipitc131_common_mode_select_pkg;

    localparam int unsigned MAX_MODES = 32;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned ENC_W     = 6;
    localparam int unsigned NO_MODE   = 0;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_PENDING = 2'd1,
        ST_REQUEST = 2'd2
    } mode_state_e;

    // Returns index+1 of the winning set flag, 0 when no flag is set.
    // The scan order puts the winning bit last so it overwrites all others.
    function automatic logic [ENC_W-1:0] encode_mode(
        input logic [MAX_MODES-1:0] flags,
        input logic                 low_first
    );
        logic [ENC_W-1:0] res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = 0; i < int'(MAX_MODES); i++) begin
            idx = low_first ? IDX_W'(MAX_MODES - 1 - 32'(i)) : IDX_W'(i);
            if (flags[idx]) begin
                res = ENC_W'(idx) + ENC_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alt_vipitc131_common_prio_encode.sv
// Combinational priority encoder for mode match flags.
//   one_hot_i     : per-mode match flags (any number may be set)
//   mode_c_o      : winning index+1, 0 when no flag set
//   multi_hot_c_o : more than one flag set
module alt_vipitc131_common_prio_encode
    import alt_vipitc131_common_mode_select_pkg::*;
#(
    parameter int unsigned NO_OF_MODES        = 3,
    parameter int unsigned LOG2_NO_OF_MODES   = 2,
    parameter int unsigned PRIORITY_LOW_FIRST = 1
) (
    input  logic [NO_OF_MODES-1:0]      one_hot_i,
    output logic [LOG2_NO_OF_MODES-1:0] mode_c_o,
    output logic                        multi_hot_c_o
);

    logic [MAX_MODES-1:0] flags_ext;
    logic [ENC_W-1:0]     mode_full;
    logic                 unused_mode_bits;

    assign flags_ext = MAX_MODES'(one_hot_i);
    assign mode_full = encode_mode(flags_ext, PRIORITY_LOW_FIRST != 0);
    assign mode_c_o  = LOG2_NO_OF_MODES'(mode_full);

    // Upper encode bits are zero whenever the width constraint holds.
    assign unused_mode_bits = ^mode_full;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot_c_o = (flags_ext & (flags_ext - MAX_MODES'(1))) != '0;

endmodule

// File: rtl/alt_vipitc131_common_mode_select.sv
// Registered, debounced mode selector. Encodes mode match flags, filters the
// result for stability and commits changes at frame boundaries through a
// req/ack handshake with the timing generator.
//   clk, rst        : clock, synchronous active-high reset
//   one_hot         : mode match flags
//   frame_boundary  : single-cycle frame switch pulse
//   mode_ack        : timing generator accepted target_mode
//   mode_change_req : request held until ack
//   target_mode     : requested mode, valid while mode_change_req=1
//   current_mode    : committed mode (index+1, 0 = none)
//   mode_valid      : current_mode != 0
//   multi_hot_err   : sampled one_hot had more than one bit set
module alt_vipitc131_common_mode_select
    import alt_vipitc131_common_mode_select_pkg::*;
#(
    parameter int unsigned NO_OF_MODES        = 3,
    parameter int unsigned LOG2_NO_OF_MODES   = 2,
    parameter int unsigned PRIORITY_LOW_FIRST = 1,
    parameter int unsigned STABLE_CYCLES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NO_OF_MODES-1:0]      one_hot,
    input  logic                        frame_boundary,
    input  logic                        mode_ack,
    output logic                        mode_change_req,
    output logic [LOG2_NO_OF_MODES-1:0] target_mode,
    output logic [LOG2_NO_OF_MODES-1:0] current_mode,
    output logic                        mode_valid,
    output logic                        multi_hot_err
);

    localparam int unsigned          CNT_W   = 8;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam int unsigned          MODE_W  = LOG2_NO_OF_MODES;
    localparam logic [MODE_W-1:0]    NONE    = MODE_W'(NO_MODE);

    logic [MODE_W-1:0] enc_c;
    logic              multi_c;

    logic [MODE_W-1:0] cand_q;
    logic [CNT_W-1:0]  stable_cnt_q;
    logic [MODE_W-1:0] stable_cand_q;
    logic              multi_hot_err_q;

    mode_state_e       state_q, state_d;
    logic [MODE_W-1:0] target_q, target_d;
    logic [MODE_W-1:0] current_q, current_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;

    alt_vipitc131_common_prio_encode #(
        .NO_OF_MODES        (NO_OF_MODES),
        .LOG2_NO_OF_MODES   (LOG2_NO_OF_MODES),
        .PRIORITY_LOW_FIRST (PRIORITY_LOW_FIRST)
    ) u_prio_encode (
        .one_hot_i     (one_hot),
        .mode_c_o      (enc_c),
        .multi_hot_c_o (multi_c)
    );

    // Candidate capture and stability filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q          <= NONE;
            stable_cnt_q    <= '0;
            stable_cand_q   <= NONE;
            multi_hot_err_q <= 1'b0;
        end else begin
            cand_q          <= enc_c;
            multi_hot_err_q <= multi_c;
            if (enc_c != cand_q) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q != CNT_MAX) begin
                stable_cnt_q <= stable_cnt_q + CNT_W'(1);
            end
            if (stable_cnt_q == CNT_MAX) begin
                stable_cand_q <= cand_q;
            end
        end
    end

    // FSM and handshake register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOCKED;
            target_q  <= NONE;
            current_q <= NONE;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            current_q <= current_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state: a change waits in PENDING for a boundary, then holds
    // target frozen in REQUEST until the timing generator acks.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        current_d = current_q;
        req_d     = req_q;
        valid_d   = valid_q;
        unique case (state_q)
            ST_LOCKED: begin
                if (stable_cand_q != current_q) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (stable_cand_q == current_q) begin
                    state_d = ST_LOCKED;
                end else if (frame_boundary) begin
                    target_d = stable_cand_q;
                    req_d    = 1'b1;
                    state_d  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (mode_ack) begin
                    current_d = target_q;
                    valid_d   = (target_q != NONE);
                    req_d     = 1'b0;
                    state_d   = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_LOCKED;
                req_d   = 1'b0;
            end
        endcase
    end

    assign mode_change_req = req_q;
    assign target_mode     = target_q;
    assign current_mode    = current_q;
    assign mode_valid      = valid_q;
    assign multi_hot_err   = multi_hot_err_q;

endmodule

// File: tb/tb_alt_vipitc131_common_mode_select.sv
// Directed bench for the debounced mode selector. A second instance with
// highest-index priority shares all inputs with the main one.
module tb_alt_vipitc131_common_mode_select;

    logic       clk;
    logic       rst;
    logic [2:0] one_hot;
    logic       frame_boundary;
    logic       mode_ack;

    logic       mode_change_req, mode_valid, multi_hot_err;
    logic [1:0] target_mode, current_mode;
    logic       hi_req, hi_valid, hi_mhe;
    logic [1:0] hi_target, hi_current;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] S_LOCKED  = 32'd0;
    localparam logic [31:0] S_PENDING = 32'd1;
    localparam logic [31:0] S_REQUEST = 32'd2;

    alt_vipitc131_common_mode_select #(
        .NO_OF_MODES(3), .LOG2_NO_OF_MODES(2), .PRIORITY_LOW_FIRST(1), .STABLE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .one_hot(one_hot), .frame_boundary(frame_boundary),
        .mode_ack(mode_ack), .mode_change_req(mode_change_req), .target_mode(target_mode),
        .current_mode(current_mode), .mode_valid(mode_valid), .multi_hot_err(multi_hot_err)
    );

    alt_vipitc131_common_mode_select #(
        .NO_OF_MODES(3), .LOG2_NO_OF_MODES(2), .PRIORITY_LOW_FIRST(0), .STABLE_CYCLES(4)
    ) dut_hi (
        .clk(clk), .rst(rst), .one_hot(one_hot), .frame_boundary(frame_boundary),
        .mode_ack(mode_ack), .mode_change_req(hi_req), .target_mode(hi_target),
        .current_mode(hi_current), .mode_valid(hi_valid), .multi_hot_err(hi_mhe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new mode, take it through PENDING, request and ack.
    task automatic go_mode(input logic [2:0] oh, input logic [1:0] exp);
        one_hot = oh;
        step(6);
        chk("go_pending", 32'(dut.state_q), S_PENDING);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("go_req", 32'(mode_change_req), 32'd1);
        chk("go_target", 32'(target_mode), 32'(exp));
        mode_ack = 1'b1;
        step(1);
        mode_ack = 1'b0;
        chk("go_current", 32'(current_mode), 32'(exp));
        chk("go_valid", 32'(mode_valid), 32'(exp != 2'd0));
        chk("go_req_low", 32'(mode_change_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        one_hot = 3'b000;
        frame_boundary = 1'b0;
        mode_ack = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        chk("rst_req", 32'(mode_change_req), 32'd0);
        chk("rst_target", 32'(target_mode), 32'd0);
        chk("rst_current", 32'(current_mode), 32'd0);
        chk("rst_valid", 32'(mode_valid), 32'd0);
        chk("rst_mhe", 32'(multi_hot_err), 32'd0);
        chk("rst_state", 32'(dut.state_q), S_LOCKED);

        // Multi-hot 3'b110: low-first picks 2, high-first picks 3
        one_hot = 3'b110;
        step(1);
        chk("mhe_lo_1", 32'(multi_hot_err), 32'd1);
        chk("mhe_hi_1", 32'(hi_mhe), 32'd1);
        step(5);
        chk("mhe_lo_6", 32'(multi_hot_err), 32'd1);
        chk("mh_pend_lo", 32'(dut.state_q), S_PENDING);
        chk("mh_pend_hi", 32'(dut_hi.state_q), S_PENDING);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("mh_req_lo", 32'(mode_change_req), 32'd1);
        chk("mh_req_hi", 32'(hi_req), 32'd1);
        chk("mh_target_lo", 32'(target_mode), 32'd2);
        chk("mh_target_hi", 32'(hi_target), 32'd3);
        mode_ack = 1'b1;
        step(1);
        mode_ack = 1'b0;
        chk("mh_cur_lo", 32'(current_mode), 32'd2);
        chk("mh_cur_hi", 32'(hi_current), 32'd3);
        one_hot = 3'b000;
        step(1);
        chk("mhe_clear", 32'(multi_hot_err), 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst2_current", 32'(current_mode), 32'd0);

        // Basic request: 3'b010, boundary on edge 12, ack three edges later
        one_hot = 3'b010;
        step(5);
        chk("t1_lock_e5", 32'(dut.state_q), S_LOCKED);
        step(1);
        chk("t1_pend_e6", 32'(dut.state_q), S_PENDING);
        chk("t1_noreq_e6", 32'(mode_change_req), 32'd0);
        step(5);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("t1_req", 32'(mode_change_req), 32'd1);
        chk("t1_target", 32'(target_mode), 32'd2);
        chk("t1_cur_before", 32'(current_mode), 32'd0);
        step(2);
        chk("t1_req_held", 32'(mode_change_req), 32'd1);
        mode_ack = 1'b1;
        step(1);
        mode_ack = 1'b0;
        chk("t1_current", 32'(current_mode), 32'd2);
        chk("t1_valid", 32'(mode_valid), 32'd1);
        chk("t1_req_low", 32'(mode_change_req), 32'd0);
        chk("t1_locked", 32'(dut.state_q), S_LOCKED);

        go_mode(3'b001, 2'd1);

        // Cancellation: 010 then back to 001 before any boundary
        one_hot = 3'b010;
        step(6);
        chk("cx_pending", 32'(dut.state_q), S_PENDING);
        one_hot = 3'b001;
        step(3);
        chk("cx_still_pend", 32'(dut.state_q), S_PENDING);
        step(3);
        chk("cx_locked", 32'(dut.state_q), S_LOCKED);
        chk("cx_noreq", 32'(mode_change_req), 32'd0);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("cx_fb_ignored", 32'(mode_change_req), 32'd0);
        chk("cx_current", 32'(current_mode), 32'd1);

        // Glitch: 001/100 every two cycles never settles
        frame_boundary = 1'b1;
        for (int k = 0; k < 8; k++) begin
            one_hot = k[0] ? 3'b001 : 3'b100;
            step(2);
            chk("gl_locked", 32'(dut.state_q), S_LOCKED);
            chk("gl_noreq", 32'(mode_change_req), 32'd0);
        end
        frame_boundary = 1'b0;
        step(6);
        chk("gl_current", 32'(current_mode), 32'd1);

        // Change during REQUEST: target frozen, re-pend after commit
        one_hot = 3'b010;
        step(6);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("rq_target2", 32'(target_mode), 32'd2);
        one_hot = 3'b100;
        step(8);
        chk("rq_frozen", 32'(target_mode), 32'd2);
        chk("rq_state", 32'(dut.state_q), S_REQUEST);
        chk("rq_req", 32'(mode_change_req), 32'd1);
        mode_ack = 1'b1;
        step(1);
        mode_ack = 1'b0;
        chk("rq_cur2", 32'(current_mode), 32'd2);
        chk("rq_locked", 32'(dut.state_q), S_LOCKED);
        step(1);
        chk("rq_repend", 32'(dut.state_q), S_PENDING);
        chk("rq_req_low", 32'(mode_change_req), 32'd0);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("rq_req3", 32'(mode_change_req), 32'd1);
        chk("rq_target3", 32'(target_mode), 32'd3);
        mode_ack = 1'b1;
        step(1);
        mode_ack = 1'b0;
        chk("rq_cur3", 32'(current_mode), 32'd3);

        // Switch to no mode
        go_mode(3'b000, 2'd0);

        // Reset while in REQUEST
        go_mode(3'b100, 2'd3);
        one_hot = 3'b001;
        step(6);
        frame_boundary = 1'b1;
        step(1);
        frame_boundary = 1'b0;
        chk("rr_state", 32'(dut.state_q), S_REQUEST);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rr_req", 32'(mode_change_req), 32'd0);
        chk("rr_current", 32'(current_mode), 32'd0);
        chk("rr_valid", 32'(mode_valid), 32'd0);
        chk("rr_target", 32'(target_mode), 32'd0);
        chk("rr_state_lock", 32'(dut.state_q), S_LOCKED);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alt_vipitc131_common_mode_select.md
Name: alt_vipitc131_common_mode_select

Overview:
Registered, debounced successor to the one-hot-to-binary mode encoder in the clocked-video-output common library.
- Priority-encodes per-mode match flags into a binary mode number: index+1, with 0 meaning no mode.
- Filters the result for stability.
- Commits a mode change only at a frame boundary, through a req/ack handshake with the timing generator.
- Sits between the mode-match comparators and the video timing generator.

Parameters:
- NO_OF_MODES, 3, number of one-hot mode flags (1..32).
- LOG2_NO_OF_MODES, 2, binary output width. Must satisfy 2**LOG2_NO_OF_MODES > NO_OF_MODES.
- PRIORITY_LOW_FIRST, 1, 1 = lowest set index wins, 0 = highest set index wins.
- STABLE_CYCLES, 4, consecutive identical candidate samples required before the candidate is acted on (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- one_hot  input  NO_OF_MODES  mode match flags. Need not be one-hot.
- frame_boundary  input  1  single-cycle pulse at the frame switch point.
- mode_ack  input  1  timing generator has accepted the requested mode.
- mode_change_req  output  1  request to switch to target_mode. Held until ack.
- target_mode  output  LOG2_NO_OF_MODES  mode being requested. Valid while mode_change_req=1.
- current_mode  output  LOG2_NO_OF_MODES  committed mode (index+1, 0 = none).
- mode_valid  output  1  current_mode != 0.
- multi_hot_err  output  1  one-cycle pulse: the sampled one_hot had more than 1 bit set.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=LOCKED, current_mode=0, target_mode=0, mode_valid=0, mode_change_req=0, multi_hot_err=0, cand_q=0, stable_cnt=0, stable_cand=0.
- Stage 1, every cycle:
  - cand_q <= encode(one_hot), using the priority set by PRIORITY_LOW_FIRST. All-zero input encodes to 0.
  - multi_hot_err <= popcount(one_hot) > 1.
- Stage 2, stability filter:
  - If encode(one_hot) != cand_q, stable_cnt <= 0.
  - Otherwise stable_cnt increments, saturating at STABLE_CYCLES-1.
  - stable_cand <= cand_q when stable_cnt == STABLE_CYCLES-1.
  - For STABLE_CYCLES=1, stable_cand follows cand_q with 1 cycle delay.
- FSM (3 states):
  - LOCKED: if stable_cand != current_mode, go to PENDING.
  - PENDING:
    - If stable_cand == current_mode, return to LOCKED (change cancelled; no request issued).
    - Else, on frame_boundary=1: target_mode <= stable_cand, mode_change_req <= 1, go to REQUEST.
    - A frame_boundary arriving in the same cycle the FSM enters PENDING is ignored; the FSM waits for the next boundary.
  - REQUEST:
    - target_mode is frozen; stable_cand changes are ignored.
    - On mode_ack=1: current_mode <= target_mode, mode_valid <= (target_mode != 0), mode_change_req <= 0, go to LOCKED.
    - If stable_cand then differs from current_mode, the FSM re-enters PENDING on the following cycle.
- mode_ack outside REQUEST is ignored. frame_boundary outside PENDING is ignored.
- Target 0 (no mode) is a legal switch. Committing it deasserts mode_valid.
- Reset in REQUEST drops mode_change_req on the next edge without a commit. current_mode returns to 0.
- Minimum latency from a one_hot change to mode_change_req=1: STABLE_CYCLES+2 cycles plus the wait for frame_boundary.
- Ack-to-commit latency: 1 cycle.

Decomposition:
- Shared package: FSM state encoding (LOCKED=0, PENDING=1, REQUEST=2), the NO_MODE=0 constant, and the encode function (index+1 priority encode with direction argument).
- Sub-module: alt_vipitc131_common_prio_encode. It is combinational, parametrised by NO_OF_MODES, LOG2_NO_OF_MODES and PRIORITY_LOW_FIRST, and outputs the binary mode plus the multi_hot flag. The top level holds all registers, the stability counter and the FSM.

Test Plan:
- Reset, then one_hot=3'b010 held; frame_boundary at cycle 12; ack 3 cycles later -> mode_change_req=1 cycle 13 with target_mode=2; current_mode=2 and mode_valid=1 the cycle after ack; req low at the same edge.
- one_hot=3'b110 with PRIORITY_LOW_FIRST=1 -> target 2, multi_hot_err pulses every sampled cycle. Repeat with PRIORITY_LOW_FIRST=0 -> target 3.
- Glitch: one_hot toggles 3'b001/3'b100 every 2 cycles with STABLE_CYCLES=4 -> stable_cand never changes, no request, FSM stays LOCKED.
- Committed mode 1; one_hot moves to 3'b010 then back to 3'b001 before frame_boundary -> PENDING then LOCKED, no mode_change_req.
- In REQUEST (target 2), one_hot switches to 3'b100 and stabilises, ack given -> current_mode=2 first, then PENDING, next boundary requests target 3.
- one_hot=0 after mode 3 committed; boundary plus ack -> current_mode=0, mode_valid=0. Assert rst while in REQUEST -> req=0 and current_mode=0 next edge.
